// File: rtl/game_mmio_slave.sv
// Avalon-MM register slave for the game: buttons, countdown timer, score, scratch.
// Optional interrupt support is enabled by defining GAME_MMIO_IRQ_EN.
module game_mmio_slave #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] ID_VALUE        = 32'h47414D45
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        avs_chipselect,
    input  logic [4:0]  avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic [31:0] avs_writedata,
    input  logic        avs_write,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [4:0]  btn_in,
    output logic [31:0] score_out,
    output logic        timer_expired,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBTN   = 5;
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NBTN-1:0]  SYNC_IDLE = {NBTN{BTN_ACTIVE_LOW}};

    localparam logic [4:0] A_ID        = 5'h00;
    localparam logic [4:0] A_CTRL      = 5'h01;
    localparam logic [4:0] A_STATUS    = 5'h02;
    localparam logic [4:0] A_BTN_STATE = 5'h03;
    localparam logic [4:0] A_BTN_EDGE  = 5'h04;
    localparam logic [4:0] A_LOAD      = 5'h05;
    localparam logic [4:0] A_COUNT     = 5'h06;
    localparam logic [4:0] A_SCORE     = 5'h07;
    localparam logic [4:0] A_SCORE_ADD = 5'h08;
    localparam logic [4:0] A_SCRATCH   = 5'h09;
    localparam logic [4:0] A_IRQ_MASK  = 5'h0A;

    logic [NBTN-1:0]   r_sync1, r_sync2, r_db;
    logic [CNT_W-1:0]  r_db_cnt [NBTN];
    logic              r_ten, r_arl, r_expired;
    logic [NBTN-1:0]   r_btn_edge;
    logic [DATA_W-1:0] r_load, r_count, r_score, r_scratch, r_readdata;

    logic              w_wr, w_rd;
    logic [DATA_W-1:0] w_be_mask, w_load_nxt, w_score_nxt, w_rdata, w_irq_mask_rd;
    logic [DATA_W:0]   w_sum;
    logic [NBTN-1:0]   w_btn, w_db_fire, w_db_rise, w_edge_clr;
    logic              w_wr_ctrl, w_sclr, w_exp_set, w_exp_clr;

    // A read coinciding with a write is dropped.
    assign w_wr      = avs_chipselect & avs_write;
    assign w_rd      = avs_chipselect & avs_read & ~avs_write;
    assign w_be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                        {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign w_wr_ctrl = w_wr && (avs_address == A_CTRL) && avs_byteenable[0];
    assign w_sclr    = w_wr_ctrl & avs_writedata[2];
    assign w_load_nxt = (r_load & ~w_be_mask) | (avs_writedata & w_be_mask);

    assign w_exp_set = r_ten && (r_count == '0);
    assign w_exp_clr = w_wr && (avs_address == A_STATUS) && avs_byteenable[0] && avs_writedata[0];
    assign w_edge_clr = {NBTN{w_wr && (avs_address == A_BTN_EDGE) && avs_byteenable[0]}}
                        & avs_writedata[NBTN-1:0];

    // Synchronisers reset to the released pin level so reset release causes no spurious bounce.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_comb begin
        w_db_fire = '0;
        for (int i = 0; i < NBTN; i++) begin
            w_db_fire[i] = (w_btn[i] != r_db[i]) && (r_db_cnt[i] == CNT_MAX);
        end
    end

    assign w_db_rise = w_db_fire & w_btn;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_db <= '0;
            for (int i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (w_btn[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_fire[i]) begin
                    r_db_cnt[i] <= '0;
                    r_db[i]     <= w_btn[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Score update: clear beats direct write beats saturating add.
    always_comb begin
        w_sum       = {1'b0, r_score} + {1'b0, avs_writedata};
        w_score_nxt = r_score;
        if (w_sclr) begin
            w_score_nxt = '0;
        end else if (w_wr && (avs_address == A_SCORE)) begin
            w_score_nxt = (r_score & ~w_be_mask) | (avs_writedata & w_be_mask);
        end else if (w_wr && (avs_address == A_SCORE_ADD)) begin
            w_score_nxt = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
        end
    end

    // Later assignments in this block take precedence: software writes override the timer.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ten      <= 1'b0;
            r_arl      <= 1'b0;
            r_expired  <= 1'b0;
            r_btn_edge <= '0;
            r_load     <= '0;
            r_count    <= '0;
            r_score    <= '0;
            r_scratch  <= '0;
        end else begin
            if (r_ten) begin
                if (r_count != '0) begin
                    r_count <= r_count - DATA_W'(1);
                end else if (r_arl) begin
                    r_count <= r_load;
                end else begin
                    r_ten <= 1'b0;
                end
            end
            if (w_wr_ctrl) begin
                r_ten <= avs_writedata[0];
                r_arl <= avs_writedata[1];
            end
            if (w_wr && (avs_address == A_LOAD)) begin
                r_load  <= w_load_nxt;
                r_count <= w_load_nxt;
            end
            if (w_wr && (avs_address == A_SCRATCH)) begin
                r_scratch <= (r_scratch & ~w_be_mask) | (avs_writedata & w_be_mask);
            end
            r_expired  <= (r_expired & ~w_exp_clr) | w_exp_set;
            r_btn_edge <= (r_btn_edge & ~w_edge_clr) | w_db_rise;
            r_score    <= w_score_nxt;
        end
    end

`ifdef GAME_MMIO_IRQ_EN
    logic [NBTN:0] r_irq_mask;
    logic          r_irq;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (avs_address == A_IRQ_MASK) && avs_byteenable[0]) begin
                r_irq_mask <= avs_writedata[NBTN:0];
            end
            r_irq <= |({r_btn_edge, r_expired} & r_irq_mask);
        end
    end

    assign irq           = r_irq;
    assign w_irq_mask_rd = {(DATA_W-NBTN-1)'(0), r_irq_mask};
`else
    assign irq           = 1'b0;
    assign w_irq_mask_rd = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            A_ID:        w_rdata = ID_VALUE;
            A_CTRL:      w_rdata = {(DATA_W-2)'(0), r_arl, r_ten};
            A_STATUS:    w_rdata = {(DATA_W-1)'(0), r_expired};
            A_BTN_STATE: w_rdata = {(DATA_W-NBTN)'(0), r_db};
            A_BTN_EDGE:  w_rdata = {(DATA_W-NBTN)'(0), r_btn_edge};
            A_LOAD:      w_rdata = r_load;
            A_COUNT:     w_rdata = r_count;
            A_SCORE:     w_rdata = r_score;
            A_SCRATCH:   w_rdata = r_scratch;
            A_IRQ_MASK:  w_rdata = w_irq_mask_rd;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_readdata <= '0;
        else                r_readdata <= w_rd ? w_rdata : '0;
    end

    assign avs_readdata  = r_readdata;
    assign score_out     = r_score;
    assign timer_expired = r_expired;

endmodule

// File: tb/tb_game_mmio_slave.sv
// Scoreboard bench for game_mmio_slave: reads push expectations, a negedge monitor compares readdata.
module tb_game_mmio_slave;

    localparam logic [4:0] A_ID = 5'h00, A_CTRL = 5'h01, A_STATUS = 5'h02, A_BTN_STATE = 5'h03;
    localparam logic [4:0] A_BTN_EDGE = 5'h04, A_LOAD = 5'h05, A_COUNT = 5'h06, A_SCORE = 5'h07;
    localparam logic [4:0] A_SCORE_ADD = 5'h08, A_SCRATCH = 5'h09, A_IRQ_MASK = 5'h0A;
`ifdef GAME_MMIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
    } rd_exp_t;

    logic        clk_clk, reset_reset_n;
    logic        avs_chipselect, avs_write, avs_read;
    logic [4:0]  avs_address;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_writedata, avs_readdata, score_out;
    logic [4:0]  btn_in;
    logic        timer_expired, irq;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;
    bit      rd_seen = 1'b0;
    int      n_checks = 0;
    int      n_fail   = 0;

    game_mmio_slave #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1),
        .ID_VALUE       (32'h47414D45)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_byteenable (avs_byteenable),
        .avs_writedata  (avs_writedata),
        .avs_write      (avs_write),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .btn_in         (btn_in),
        .score_out      (score_out),
        .timer_expired  (timer_expired),
        .irq            (irq)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        tick();
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back('{exp, a});
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = a;
        tick();
        avs_chipselect = 1'b0; avs_read = 1'b0;
    endtask

    // Note which edges captured a read access; the following negedge owns its readdata.
    always @(posedge clk_clk) begin
        rd_seen <= avs_chipselect & avs_read & ~avs_write & reset_reset_n;
    end

    always @(negedge clk_clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", avs_readdata, 32'hxxxx_xxxx);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("rd_addr_%02h", mon_e.addr), avs_readdata, mon_e.data);
            end
        end else begin
            check("rd_idle_zero", avs_readdata, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset_n = 1'b0;
        avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
        avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
        btn_in = 5'h1F;
        ticks(3);
        reset_reset_n = 1'b1;
        tick();

        // Reset state and ID
        check("rst_score_out", score_out, 32'h0);
        check("rst_timer_expired", 32'(timer_expired), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        bus_read(A_ID, 32'h47414D45);
        bus_read(A_IRQ_MASK, 32'h0);
        bus_read(A_COUNT, 32'h0);
        tick();

        // One-shot countdown
        bus_write(A_LOAD, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int v = 5; v >= 0; v--) bus_read(A_COUNT, 32'(v));
        bus_read(A_STATUS, 32'h1);
        bus_read(A_CTRL, 32'h0);
        check("expired_out_set", 32'(timer_expired), 32'h1);
        bus_read(A_COUNT, 32'h0);
        bus_write(A_STATUS, 32'h1, 4'hF);
        bus_read(A_STATUS, 32'h0);
        check("expired_out_clr", 32'(timer_expired), 32'h0);

        // Button bounce shorter than the debounce window
        btn_in[2] = 1'b0;
        ticks(3);
        btn_in[2] = 1'b1;
        ticks(6);
        bus_read(A_BTN_STATE, 32'h0);
        bus_read(A_BTN_EDGE, 32'h0);
        btn_in[2] = 1'b0;
        ticks(10);
        bus_read(A_BTN_STATE, 32'h4);
        bus_read(A_BTN_EDGE, 32'h4);
        // Release: no edge on the falling side; then clear the edge
        btn_in[2] = 1'b1;
        ticks(10);
        bus_read(A_BTN_STATE, 32'h0);
        bus_write(A_BTN_EDGE, 32'h4, 4'hF);
        bus_read(A_BTN_EDGE, 32'h0);
        // Press again with the W1C landing on the same edge the debounced state rises
        btn_in[2] = 1'b0;
        ticks(5);
        bus_write(A_BTN_EDGE, 32'h4, 4'hF);
        bus_read(A_BTN_STATE, 32'h4);
        bus_read(A_BTN_EDGE, 32'h4);
        btn_in[2] = 1'b1;
        ticks(10);

        // Score saturation, full-word add, clear
        bus_write(A_SCORE, 32'hFFFFFFF0, 4'hF);
        check("score_direct", score_out, 32'hFFFFFFF0);
        bus_write(A_SCORE_ADD, 32'h20, 4'hF);
        check("score_saturate", score_out, 32'hFFFFFFFF);
        bus_write(A_SCORE, 32'd10, 4'hF);
        bus_write(A_SCORE_ADD, 32'h00010005, 4'h0);
        check("score_add_ignores_be", score_out, 32'h0001000F);
        bus_read(A_SCORE_ADD, 32'h0);
        bus_write(A_CTRL, 32'h4, 4'hF);
        check("score_sclr", score_out, 32'h0);
        bus_read(A_CTRL, 32'h0);

        // Byte lanes and unmapped address
        bus_write(A_SCRATCH, 32'hAABBCCDD, 4'hF);
        bus_write(A_SCRATCH, 32'h11223344, 4'b0101);
        bus_read(A_SCRATCH, 32'hAA22CC44);
        bus_write(5'h1F, 32'hFFFFFFFF, 4'hF);
        bus_read(5'h1F, 32'h0);
        bus_read(A_SCRATCH, 32'hAA22CC44);
        bus_read(A_SCORE, 32'h0);

        // Interrupt on timer expiry with auto-reload
        bus_write(A_IRQ_MASK, 32'h1, 4'hF);
        bus_read(A_IRQ_MASK, IRQ_EN ? 32'h1 : 32'h0);
        bus_write(A_LOAD, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'hF);
        check("arl_expired_early", 32'(timer_expired), 32'h0);
        ticks(2);
        check("arl_expired_pre", 32'(timer_expired), 32'h0);
        check("irq_pre", 32'(irq), 32'h0);
        tick();
        check("arl_expired_set", 32'(timer_expired), 32'h1);
        check("irq_lag", 32'(irq), 32'h0);
        tick();
        check("irq_rise", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        bus_read(A_CTRL, 32'h3);

        // Reset lands between the read's capture edge and its readdata sample
        exp_q.push_back('{32'h0, A_COUNT});
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = A_COUNT;
        @(posedge clk_clk);
        #2;
        reset_reset_n = 1'b0;
        avs_chipselect = 1'b0; avs_read = 1'b0;
        #1;
        check("rst_mid_irq", 32'(irq), 32'h0);
        check("rst_mid_expired", 32'(timer_expired), 32'h0);
        ticks(2);
        reset_reset_n = 1'b1;
        tick();
        bus_read(A_COUNT, 32'h0);
        bus_read(A_CTRL, 32'h0);
        bus_read(A_STATUS, 32'h0);
        bus_read(A_SCRATCH, 32'h0);
        bus_read(A_IRQ_MASK, 32'h0);
        ticks(3);
        check("post_rst_irq", 32'(irq), 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
